// File: rtl/fq_id_pkg.sv
// ---------------------------------------------------------------------------
// fq_id_pkg
// Shared types and constants for the fetch-queue -> decode boundary.
//   INST_NOP / PC_RESET : default bubble-bundle instruction word and pc
//   EXCP_W / FLAG_W     : exception-code and flag widths
//   MAX_LANES           : widest bundle the struct can carry; narrower
//                         configurations use the low lanes only
//   fq_bundle_t         : one instruction bundle as held in the queue
//   make_bubble()       : builds the bundle shown when the queue is empty
// ---------------------------------------------------------------------------
package fq_id_pkg;

    localparam int          MAX_LANES = 4;
    localparam int          EXCP_W    = 7;
    localparam int          FLAG_W    = 2;
    localparam logic [31:0] INST_NOP  = 32'h0340_0000;
    localparam logic [31:0] PC_RESET  = 32'h1c00_0000;

    typedef struct packed {
        logic [MAX_LANES-1:0][31:0] inst;
        logic [MAX_LANES-1:0]       lane_vld;
        logic [31:0]                pc;
        logic [31:0]                badv;
        logic [31:0]                cookie;
        logic [EXCP_W-1:0]          excp;
        logic [FLAG_W-1:0]          excp_flag;
        logic [FLAG_W-1:0]          priv_flag;
    } fq_bundle_t;

    // Bubble bundle: NOP in every lane, no valid lanes, pc/badv at the reset pc.
    function automatic fq_bundle_t make_bubble(input logic [31:0] pc_reset,
                                               input logic [31:0] inst_nop);
        fq_bundle_t b;
        for (int i = 0; i < MAX_LANES; i++) begin
            b.inst[i] = inst_nop;
        end
        b.lane_vld  = '0;
        b.pc        = pc_reset;
        b.badv      = pc_reset;
        b.cookie    = '0;
        b.excp      = '0;
        b.excp_flag = '0;
        b.priv_flag = '0;
        return b;
    endfunction

endpackage

// File: rtl/fq_id_store.sv
// ---------------------------------------------------------------------------
// fq_id_store
// DEPTH-entry bundle storage: one synchronous write port, one asynchronous
// read port. Entries carry no reset; only the queue control state does.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   bundle to store
//   raddr  in   read index
//   rdata  out  bundle at raddr (combinational)
// ---------------------------------------------------------------------------
module fq_id_store
    import fq_id_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  fq_bundle_t       wdata,
    input  logic [PTR_W-1:0] raddr,
    output fq_bundle_t       rdata
);

    fq_bundle_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fq_id_skid_queue.sv
// ---------------------------------------------------------------------------
// fq_id_skid_queue
// Fetch-queue -> decode boundary: DEPTH-entry circular queue of LANES-wide
// instruction bundles. in_ready is registered so decode never sees a
// combinational ready path back to fetch. An empty queue presents a NOP
// bubble bundle on out_*.
// Optional feature: define FQ_ID_PERF_EN to add perf_stall_cnt and
// perf_bubble_cnt outputs.
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   flush                     pipeline redirect; empties the queue
//   in_valid / in_ready       upstream handshake (in_ready registered)
//   in_inst, in_lane_vld,     incoming bundle: lane i inst at [32*i+:32],
//   in_pc, in_badv, in_cookie,  per-lane valid, lane-0 pc, bad vaddr,
//   in_excp, in_excp_flag,      predictor cookie, exception code/flag,
//   in_priv_flag                privilege flag
//   out_valid / out_ready     downstream handshake
//   out_* (as in_*)           head bundle, or bubble when empty
//   out_pc_next               out_pc + 4*LANES
//   count                     occupancy
//   perf_stall_cnt            (FQ_ID_PERF_EN) cycles of in_valid & ~in_ready
//   perf_bubble_cnt           (FQ_ID_PERF_EN) cycles of out_ready & ~out_valid
// ---------------------------------------------------------------------------
module fq_id_skid_queue
    import fq_id_pkg::*;
#(
    parameter  int          LANES    = 2,
    parameter  int          DEPTH    = 2,
    parameter  logic [31:0] PC_RESET = fq_id_pkg::PC_RESET,
    parameter  logic [31:0] INST_NOP = fq_id_pkg::INST_NOP,
    localparam int          CNT_W    = $clog2(DEPTH + 1),
    localparam int          PTR_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*LANES-1:0] in_inst,
    input  logic [LANES-1:0]    in_lane_vld,
    input  logic [31:0]         in_pc,
    input  logic [31:0]         in_badv,
    input  logic [31:0]         in_cookie,
    input  logic [EXCP_W-1:0]   in_excp,
    input  logic [FLAG_W-1:0]   in_excp_flag,
    input  logic [FLAG_W-1:0]   in_priv_flag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*LANES-1:0] out_inst,
    output logic [LANES-1:0]    out_lane_vld,
    output logic [31:0]         out_pc,
    output logic [31:0]         out_pc_next,
    output logic [31:0]         out_badv,
    output logic [31:0]         out_cookie,
    output logic [EXCP_W-1:0]   out_excp,
    output logic [FLAG_W-1:0]   out_excp_flag,
    output logic [FLAG_W-1:0]   out_priv_flag,
`ifdef FQ_ID_PERF_EN
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_bubble_cnt,
`endif
    output logic [CNT_W-1:0]    count
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;
    fq_bundle_t       wr_bundle;
    fq_bundle_t       rd_bundle;
    fq_bundle_t       head;
    fq_bundle_t       bubble;
    logic             unused_head_lanes;

    assign bubble    = make_bubble(PC_RESET, INST_NOP);
    assign out_valid = (count != '0);

    // flush kills both handshakes in the same cycle
    assign push       = in_valid & in_ready & ~flush;
    assign pop        = out_valid & out_ready & ~flush;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    // Lanes above LANES default to NOP so the stored struct is fully defined.
    // An excepting bundle keeps only lane 0; the rest become NOPs.
    always_comb begin
        wr_bundle = bubble;
        for (int i = 0; i < LANES; i++) begin
            wr_bundle.inst[i] = in_inst[32*i +: 32];
        end
        wr_bundle.lane_vld[LANES-1:0] = in_lane_vld;
        wr_bundle.pc        = in_pc;
        wr_bundle.badv      = in_badv;
        wr_bundle.cookie    = in_cookie;
        wr_bundle.excp      = in_excp;
        wr_bundle.excp_flag = in_excp_flag;
        wr_bundle.priv_flag = in_priv_flag;
        if (in_excp_flag != '0) begin
            wr_bundle.lane_vld = MAX_LANES'(1);
            for (int i = 1; i < LANES; i++) begin
                wr_bundle.inst[i] = INST_NOP;
            end
        end
    end

    fq_id_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_bundle),
        .raddr (rd_ptr),
        .rdata (rd_bundle)
    );

    // Control state. in_ready is the registered form of (count < DEPTH), so a
    // pop while full only reopens the input on the following cycle.
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_next;
            in_ready <= (count_next < CNT_W'(DEPTH));
        end
    end

    assign head = (count == '0) ? bubble : rd_bundle;

    always_comb begin
        out_inst = '0;
        for (int i = 0; i < LANES; i++) begin
            out_inst[32*i +: 32] = head.inst[i];
        end
    end

    assign out_lane_vld  = head.lane_vld[LANES-1:0];
    assign out_pc        = head.pc;
    assign out_pc_next   = head.pc + 32'(4 * LANES);
    assign out_badv      = head.badv;
    assign out_cookie    = head.cookie;
    assign out_excp      = head.excp;
    assign out_excp_flag = head.excp_flag;
    assign out_priv_flag = head.priv_flag;

    // Lanes beyond LANES exist in the shared struct but are never presented.
    assign unused_head_lanes = ^{head.inst, head.lane_vld};

`ifdef FQ_ID_PERF_EN
    // Perf counters survive flush; only reset clears them. Both wrap freely.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (in_valid && !in_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (out_ready && !out_valid) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
